cla_arbiter: RTL and testbench

CLA_ARBITER -- requirements
Module: cla_arbiter

---
 rtl/cla_arbiter.sv | 136 +++++++++++++
 tb/tb_cla_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_arbiter.sv
// Two-requester round-robin front end sharing one 11-bit carry-lookahead adder.
// Each operation runs IDLE (grant) -> EXEC (add) -> RESP (hold until consumed).

module CLA_11bit (
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic [10:0] sum,
  output logic        cout
);

  logic [10:0] g;
  logic [10:0] p;
  logic [11:0] c;
  logic        term;

  assign g = a & b;
  assign p = a ^ b;

  // Full lookahead: c[i+1] = OR over j<=i of g[j] & p[j+1] & ... & p[i]
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop; a path that skips one would infer a latch.
    c    = '0;
    term = 1'b0;
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign sum  = p ^ c[10:0];
  assign cout = c[11];

endmodule

module cla_arbiter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic         last_grant;
  logic         winner;
  logic         grant;
  logic [W-1:0] op_a, op_b;
  logic         op_id;
  logic [W-1:0] add_sum;
  logic         add_cout;

  CLA_11bit u_cla (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Contention goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    winner     = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          grant      = 1'b1;
          req0_ready = ~winner;
          req1_ready = winner;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values regardless of block order.
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant) last_grant <= winner;
    end
  end

  // NOTE: operand registers carry no reset; a grant always writes them before EXEC reads them.
  always_ff @(posedge clk) begin
    if (grant) begin
      op_a  <= winner ? req1_a : req0_a;
      op_b  <= winner ? req1_b : req0_b;
      op_id <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
      rsp_id   <= op_id;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cla_arbiter.sv
// Directed and randomized checks for cla_arbiter: reset, contention order,
// arithmetic table, backpressure, mid-operation reset and a scoreboarded random run.

module tb_cla_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [10:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready;
  logic [10:0] rsp_sum;
  logic        rsp_cout, rsp_id, busy;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        v0, v1;
    logic [10:0] a0, b0, a1, b1;
    logic        id;
    logic [10:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[10];

  cla_arbiter #(.W(11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full IDLE->EXEC->RESP pass with rsp_ready high.
  task automatic run_op(input string tag, input vec_t v, input bit hold);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    rsp_ready  = 1'b1;
    @(negedge clk);
    check({tag, " idle ready0"}, 32'(req0_ready), 32'(v.id == 1'b0));
    check({tag, " idle ready1"}, 32'(req1_ready), 32'(v.id == 1'b1));
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    tick();
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    @(negedge clk);
    check({tag, " exec readies"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    check({tag, " exec busy/valid"}, {30'd0, busy, rsp_valid}, 32'b10);
    tick();
    @(negedge clk);
    check({tag, " resp valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " resp id/cout/sum"}, {19'd0, rsp_id, rsp_cout, rsp_sum}, {19'd0, v.id, v.cout, v.sum});
    tick();
  endtask

  initial begin : main
    vec_t        c0, c1;
    int          m_state, n_ops;
    logic        m_last, g, w;
    logic [12:0] exp_rsp;
    logic [11:0] s12;

    vecs[0] = '{1'b1, 1'b0, 11'h3FF, 11'h001, 11'h000, 11'h000, 1'b0, 11'h400, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 11'h005, 11'h006, 11'h400, 11'h400, 1'b1, 11'h000, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 11'h005, 11'h006, 11'h400, 11'h400, 1'b0, 11'h00B, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 11'h000, 11'h000, 11'h7FF, 11'h7FF, 1'b1, 11'h7FE, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 11'h000, 11'h000, 11'h000, 11'h000, 1'b1, 11'h000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 11'h555, 11'h2AA, 11'h001, 11'h001, 1'b0, 11'h7FF, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 11'h7FF, 11'h001, 11'h000, 11'h000, 1'b0, 11'h000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 11'h123, 11'h456, 11'h000, 11'h000, 1'b0, 11'h579, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 11'h001, 11'h001, 11'h400, 11'h3FF, 1'b1, 11'h7FF, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 11'h700, 11'h100, 11'h002, 11'h003, 1'b0, 11'h000, 1'b1};

    // Reset held with both requesters asking: nothing may be granted.
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 11'h005; req0_b = 11'h006;
    req1_valid = 1'b1; req1_a = 11'h400; req1_b = 11'h400;
    tick();
    @(negedge clk);
    check("reset readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("reset rsp_valid/busy", {30'd0, rsp_valid, busy}, 32'd0);
    check("reset id/cout/sum", {19'd0, rsp_id, rsp_cout, rsp_sum}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Continuous contention straight out of reset: grants 0,1,0,1.
    c0 = '{1'b1, 1'b1, 11'h005, 11'h006, 11'h400, 11'h400, 1'b0, 11'h00B, 1'b0};
    c1 = '{1'b1, 1'b1, 11'h005, 11'h006, 11'h400, 11'h400, 1'b1, 11'h000, 1'b1};
    for (int k = 0; k < 4; k++) run_op($sformatf("contend%0d", k), (k % 2 == 0) ? c0 : c1, 1'b1);

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Backpressure: response held for 10 cycles while req1 waits.
    req0_valid = 1'b1; req0_a = 11'h0F0; req0_b = 11'h00F; rsp_ready = 1'b0;
    @(negedge clk);
    check("bp grant0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 11'h200; req1_b = 11'h300;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d valid/ready1", i), {30'd0, rsp_valid, req1_ready}, 32'b10);
      check($sformatf("bp hold%0d id/cout/sum", i), {19'd0, rsp_id, rsp_cout, rsp_sum}, 32'h0FF);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release no grant", {30'd0, rsp_valid, req1_ready}, 32'b10);
    tick();
    @(negedge clk);
    check("bp next idle grant1", {30'd0, req1_ready, req0_ready}, 32'b10);
    check("bp idle sum held", 32'(rsp_sum), 32'h0FF);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp exec sum held", 32'(rsp_sum), 32'h0FF);
    tick();
    @(negedge clk);
    check("bp resp1 id/cout/sum", {19'd0, rsp_id, rsp_cout, rsp_sum}, {19'd0, 1'b1, 1'b0, 11'h500});
    tick();

    // Reset during EXEC discards the operation.
    req0_valid = 1'b1; req0_a = 11'h3FF; req0_b = 11'h001;
    @(negedge clk);
    check("rst-mid grant0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    check("rst-mid readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rst_n = 1'b1; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst-mid idle%0d valid/busy", i), {30'd0, rsp_valid, busy}, 32'd0);
      check($sformatf("rst-mid idle%0d id/cout/sum", i), {19'd0, rsp_id, rsp_cout, rsp_sum}, 32'd0);
      tick();
    end
    run_op("rst-mid ptr", c0, 1'b0);

    // Random traffic against a cycle model; pointer is 0 after the last grant above.
    m_state = 0; m_last = 1'b0; n_ops = 0; exp_rsp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = 11'($urandom()); req0_b = 11'($urandom());
      req1_a = 11'($urandom()); req1_b = 11'($urandom());
      rsp_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      g = (m_state == 0) && (req0_valid || req1_valid);
      w = (req0_valid && req1_valid) ? ~m_last : ~req0_valid;
      check("rand ready0", 32'(req0_ready), 32'(g && !w));
      check("rand ready1", 32'(req1_ready), 32'(g && w));
      check("rand rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
      if (m_state == 2) check("rand id/cout/sum", {19'd0, rsp_id, rsp_cout, rsp_sum}, {19'd0, exp_rsp});
      case (m_state)
        0: if (g) begin
          s12     = w ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
          exp_rsp = {w, s12};
          m_last  = w;
          m_state = 1;
        end
        1: m_state = 2;
        default: if (rsp_ready) begin
          m_state = 0;
          n_ops++;
        end
      endcase
      tick();
    end
    check("rand ops completed", 32'(n_ops >= 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
